// File: rtl/bcd2_to_bin.sv
// Sequential BCD-to-binary converter (reverse double-dabble, one bit per cycle).
// Accepts NDIG packed BCD digits plus a sign flag and returns a two's-complement result.
module bcd2_to_bin #(
    parameter int NDIG  = 2,
    parameter int OUT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       d1,
    input  logic [3:0]       d2,
    input  logic             neg,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [OUT_W-1:0] numero
);

    localparam int BW = 4 * NDIG;
    localparam int CW = $clog2(BW);
    localparam logic [CW-1:0] LAST_CNT = CW'(BW - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        SIGN  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state_r;
    logic [CW-1:0]     cnt_r;
    logic [2*BW-1:0]   sr_r;
    logic              neg_r;
    logic [BW-1:0]     bcd_in_s;
    logic [OUT_W-1:0]  mag_s;
    logic [OUT_W-1:0]  signed_s;

    // Returns 1 when every 4-bit digit is a legal BCD value.
    function automatic logic digits_valid(input logic [BW-1:0] v);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < NDIG; i++) begin
            if (v[4*i +: 4] > 4'd9) begin
                ok = 1'b0;
            end else begin
                ok = ok;
            end
        end
        return ok;
    endfunction

    // One reverse double-dabble step: shift right, then correct digits that reached 8 or more.
    function automatic logic [2*BW-1:0] dabble_step(input logic [2*BW-1:0] v);
        logic [2*BW-1:0] t;
        t = v >> 1;
        for (int i = 0; i < NDIG; i++) begin
            if (t[BW + 4*i +: 4] >= 4'd8) begin
                t[BW + 4*i +: 4] = t[BW + 4*i +: 4] - 4'd3;
            end else begin
                t[BW + 4*i +: 4] = t[BW + 4*i +: 4];
            end
        end
        return t;
    endfunction

    // Digit bundle, magnitude extension and conditional negation of the finished binary value.
    always_comb begin
        bcd_in_s = {d2, d1};
        mag_s    = {{(OUT_W-BW){1'b0}}, sr_r[BW-1:0]};
        if (neg_r) begin
            signed_s = ~mag_s + OUT_W'(1'b1);
        end else begin
            signed_s = mag_s;
        end
    end

    // Control FSM and datapath; every output is a register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
            cnt_r   <= '0;
            sr_r    <= '0;
            neg_r   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            numero  <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        neg_r <= neg;
                        if (!digits_valid(bcd_in_s)) begin
                            err     <= 1'b1;
                            numero  <= '0;
                            done    <= 1'b1;
                            state_r <= DONE;
                        end else begin
                            err     <= 1'b0;
                            sr_r    <= {bcd_in_s, {BW{1'b0}}};
                            cnt_r   <= '0;
                            busy    <= 1'b1;
                            state_r <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    sr_r  <= dabble_step(sr_r);
                    cnt_r <= cnt_r + CW'(1'b1);
                    if (cnt_r == LAST_CNT) begin
                        state_r <= SIGN;
                    end
                end
                SIGN: begin
                    numero  <= signed_s;
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    state_r <= DONE;
                end
                DONE: begin
                    done    <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule
